// File: rtl/fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_packer
// Description : Write-side framing stage in front of an async FIFO. Forwards
//               each accepted stream word to the FIFO write port one cycle
//               later, then appends an XOR-checksum trailer word per packet.
//               Packets longer than MAX_PKT words are truncated: the trailer
//               is inverted, err_len pulses, and the excess words are drained.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_packer #(
  parameter int DATA_W  = 8,
  parameter int MAX_PKT = 8
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        pkt_cnt,
  output logic              err_len
);

  // Word counter must be able to hold MAX_PKT itself.
  localparam int               CNT_W   = $clog2(MAX_PKT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_TRAIL = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] csum;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  wcnt_inc;
  logic              trunc;

  logic              ready_raw;
  logic              accept;
  logic              take_data;
  logic              at_limit;
  logic              cut_now;
  logic              launch_trailer;
  logic [DATA_W-1:0] trailer_word;

  // Per-state readiness; DROP drains regardless of FIFO level, reset blocks all.
  always_comb begin
    ready_raw = 1'b0;
    case (state)
      ST_IDLE:  ready_raw = !fifo_full;
      ST_PASS:  ready_raw = !fifo_full;
      ST_TRAIL: ready_raw = 1'b0;
      ST_DROP:  ready_raw = 1'b1;
      default:  ready_raw = 1'b0;
    endcase
    s_ready = ready_raw && !reset;
  end

  // Handshake qualification and packet-length bookkeeping.
  always_comb begin
    accept         = s_valid && s_ready;
    take_data      = accept && ((state == ST_IDLE) || (state == ST_PASS));
    wcnt_inc       = wcnt + CNT_W'(1);
    at_limit       = (wcnt_inc == CNT_MAX);
    // A word without s_last that fills the packet to MAX_PKT forces truncation.
    cut_now        = take_data && !s_last && at_limit;
    launch_trailer = (state == ST_TRAIL) && !fifo_full;
    trailer_word   = trunc ? ~csum : csum;
  end

  // Next-state selection for the framing FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_PASS: begin
        if (take_data) begin
          if (s_last || at_limit) begin
            state_nxt = ST_TRAIL;
          end else begin
            state_nxt = ST_PASS;
          end
        end
      end
      ST_TRAIL: begin
        if (!fifo_full) begin
          state_nxt = trunc ? ST_DROP : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (accept && s_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register; reset discards any partially received packet.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Running checksum, word count and truncation flag for the open packet.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      csum  <= '0;
      wcnt  <= '0;
      trunc <= 1'b0;
    end else if (launch_trailer) begin
      csum  <= '0;
      wcnt  <= '0;
      trunc <= 1'b0;
    end else if (take_data) begin
      csum  <= csum ^ s_data;
      wcnt  <= wcnt_inc;
      trunc <= cut_now;
    end
  end

  // Registered FIFO write port: data words and trailers share one strobe.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
      err_len <= 1'b0;
    end else begin
      wr_en   <= take_data || launch_trailer;
      err_len <= launch_trailer && trunc;
      if (launch_trailer) begin
        wr_data <= trailer_word;
      end else if (take_data) begin
        wr_data <= s_data;
      end
    end
  end

  // Closed-packet counter, advanced when the trailer is written; wraps freely.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      pkt_cnt <= 8'd0;
    end else if (launch_trailer) begin
      pkt_cnt <= pkt_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_packer
// Description : Self-checking bench for fifo_wr_packer. Directed scenarios
//               plus randomized packets; a packet-level reference model
//               predicts every FIFO write and the closed-packet count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_packer;

  localparam int DATA_W  = 8;
  localparam int MAX_PKT = 8;

  logic              wr_clk = 1'b0;
  logic              reset;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              fifo_full;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [7:0]        pkt_cnt;
  logic              err_len;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pkt_words[$];
  int         wtimes[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_pkts = 0;
  int         cyc = 0;
  logic       rand_full_en = 1'b0;

  fifo_wr_packer #(.DATA_W(DATA_W), .MAX_PKT(MAX_PKT)) dut (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .pkt_cnt   (pkt_cnt),
    .err_len   (err_len)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Random backpressure, applied just after the edge so it is stable at sampling.
  always @(posedge wr_clk) begin
    #1;
    if (rand_full_en) fifo_full = ($urandom_range(0, 99) < 30);
  end

  // Write monitor: every strobe must match the next predicted word.
  always @(negedge wr_clk) begin
    exp_t e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        check("err_len", {31'd0, err_len}, {31'd0, e.err});
        wtimes.push_back(cyc);
      end
    end else if (err_len !== 1'b0 && reset === 1'b0) begin
      check("err_len_no_write", {31'd0, err_len}, 32'd0);
    end
  end

  // Reference model: what the FIFO must receive for a whole packet.
  task automatic predict_packet();
    int         n;
    int         m;
    logic [7:0] x;
    n = pkt_words.size();
    m = (n > MAX_PKT) ? MAX_PKT : n;
    x = 8'h00;
    for (int i = 0; i < m; i++) begin
      exp_q.push_back('{data: pkt_words[i], err: 1'b0});
      x = x ^ pkt_words[i];
    end
    if (n > MAX_PKT) exp_q.push_back('{data: ~x, err: 1'b1});
    else             exp_q.push_back('{data: x, err: 1'b0});
    exp_pkts++;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send_word(input logic [7:0] d, input logic l);
    int   n;
    logic ok;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge wr_clk);
      ok = s_ready;
      @(posedge wr_clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Send the packet held in pkt_words, optionally with idle gaps.
  task automatic send_pkt(input bit gaps);
    int n;
    n = pkt_words.size();
    predict_packet();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          s_last  = 1'($urandom_range(0, 1));
          s_data  = 8'($urandom);
          @(posedge wr_clk);
          #1;
        end
      end
      send_word(pkt_words[i], (i == n - 1));
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic check_cnt(input string tag);
    @(negedge wr_clk);
    check(tag, {24'd0, pkt_cnt}, 32'(exp_pkts % 256));
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    reset     = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'h55;
    s_last    = 1'b0;
    fifo_full = 1'b0;

    // 1: reset with valid asserted
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_wr_en",   {31'd0, wr_en},   32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
    check("rst_err_len", {31'd0, err_len}, 32'd0);
    @(posedge wr_clk);
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    idle(1);

    // 2: three-word packet, back-to-back writes including trailer 0x70
    pkt_words = '{8'h12, 8'h34, 8'h56};
    send_pkt(1'b0);
    idle(3);
    s = wtimes.size();
    check("t2_write_count", 32'(s), 32'd4);
    if (s >= 4) check("t2_consecutive", 32'(wtimes[s-1] - wtimes[s-4]), 32'd3);
    check_cnt("t2_pkt_cnt");

    // 3: single-word packet
    pkt_words = '{8'hA5};
    send_pkt(1'b0);
    idle(3);
    check_cnt("t3_pkt_cnt");

    // 4: backpressure while the trailer is pending
    pkt_words = '{8'h3C};
    predict_packet();
    s_valid = 1'b1;
    s_data  = 8'h3C;
    s_last  = 1'b1;
    @(negedge wr_clk);
    check("t4_ready_idle", {31'd0, s_ready}, 32'd1);
    @(posedge wr_clk);
    #1;
    fifo_full = 1'b1;
    s_data    = 8'h99;
    s_last    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wr_clk);
      check("t4_ready_full", {31'd0, s_ready}, 32'd0);
      if (i > 0) check("t4_no_write", {31'd0, wr_en}, 32'd0);
      @(posedge wr_clk);
      #1;
    end
    fifo_full = 1'b0;
    s_valid   = 1'b0;
    @(negedge wr_clk);
    check("t4_no_write_yet", {31'd0, wr_en}, 32'd0);
    @(negedge wr_clk);
    check("t4_trailer_strobe", {31'd0, wr_en}, 32'd1);
    idle(2);
    check_cnt("t4_pkt_cnt");

    // 5: ten-word packet truncated after MAX_PKT words, trailer ~0x08
    pkt_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    predict_packet();
    for (int i = 0; i < 8; i++) send_word(pkt_words[i], 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h09;
    s_last  = 1'b0;
    @(negedge wr_clk);
    check("t5_ready_trail", {31'd0, s_ready}, 32'd0);
    @(posedge wr_clk);
    #1;
    fifo_full = 1'b1;
    @(negedge wr_clk);
    check("t5_ready_drop_full", {31'd0, s_ready}, 32'd1);
    @(posedge wr_clk);
    #1;
    send_word(8'h0A, 1'b1);
    fifo_full = 1'b0;
    idle(3);
    check("t5_queue_drained", 32'(exp_q.size()), 32'd0);
    check_cnt("t5_pkt_cnt");

    // 6: reset in mid-packet discards it; next packet framed normally
    exp_q.push_back('{data: 8'h21, err: 1'b0});
    exp_q.push_back('{data: 8'h22, err: 1'b0});
    send_word(8'h21, 1'b0);
    send_word(8'h22, 1'b0);
    reset = 1'b1;
    idle(2);
    reset    = 1'b0;
    exp_pkts = 0;
    idle(1);
    check("t6_no_trailer", 32'(exp_q.size()), 32'd0);
    check_cnt("t6_pkt_cnt_cleared");
    pkt_words = '{8'h0F};
    send_pkt(1'b0);
    idle(3);
    check_cnt("t6_pkt_cnt");

    // Randomized packets with gaps and random backpressure
    rand_full_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int n;
      n = $urandom_range(1, 12);
      pkt_words.delete();
      for (int i = 0; i < n; i++) pkt_words.push_back(8'($urandom));
      send_pkt(1'b1);
    end
    rand_full_en = 1'b0;
    #2;
    fifo_full = 1'b0;
    idle(10);
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    check_cnt("rand_pkt_cnt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
